divclk_seq: RTL
===============

Name: divclk_seq

Overview:
Programmable tick-pattern sequencer built around a reloadable divider core. It holds a small table of (divisor, tick-count) steps and plays them in order, emitting one-cycle tick pulses at each step's rate. It optionally loops the pattern. Software or an upstream FSM loads the table, pulses start, and watches busy/done; downstream timing logic consumes tick_out exactly as it consumes a divider output.

Parameters:
BIT_SZ, 16, width of divisor k; tick period is k+1 clk_in cycles.
CNT_SZ, 8, width of per-step tick count.
STEPS, 4, table depth; power of two; index width is log2(STEPS).

Ports:
clk_in  input  1  system clock; all state changes on its rising edge.
rst_n  input  1  asynchronous active-low reset.
cfg_we  input  1  table write strobe; honoured only while idle.
cfg_addr  input  log2(STEPS)  table entry to write.
cfg_k  input  BIT_SZ  divisor for the entry.
cfg_len  input  CNT_SZ  ticks emitted by the entry; 0 is treated as 1.
cfg_last  input  log2(STEPS)  index of the final step; sampled at start.
loop  input  1  sampled at start; 1 means restart at step 0 after the last step.
start  input  1  level-sampled request to begin; honoured only in IDLE.
stop  input  1  abort; honoured in any state.
tick_out  output  1  one-cycle tick pulse.
busy  output  1  high in RUN.
done  output  1  one-cycle pulse on natural completion.
step_idx  output  log2(STEPS)  current step.
k_cur  output  BIT_SZ  divisor in use.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all table entries k=0, len=0; tick_out=0, busy=0, done=0, step_idx=0, k_cur=0; internal counters 0.
- Table write: on an edge with cfg_we=1 and state IDLE, entry[cfg_addr] is written with {cfg_k, cfg_len}. Writes in RUN or DONE are dropped silently.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN: on an edge S with start=1 and stop=0.
    - Latch cfg_last and loop.
    - step_idx←0, k_cur←entry[0].k, div_cnt←entry[0].k, left←max(entry[0].len,1).
    - busy=1 from S.
  - RUN: each edge, if div_cnt==0, set tick_out=1 for the following cycle, div_cnt←k_cur, and left←left-1. Otherwise div_cnt←div_cnt-1 and tick_out=0.
    - First tick begins at edge S+(k0+1); period is k+1 cycles. With k=0, tick_out stays high every cycle.
  - Step end: on the edge carrying the step's final tick, load the next step in the same edge. Its first tick therefore arrives k_next+1 edges later.
    - If step_idx≠last: step_idx+1.
    - Else if loop: step_idx←0.
    - Else: go to DONE.
  - RUN→DONE: busy←0 and done←1 at the edge after the final tick edge, so done is high for exactly one cycle. tick_out is 0 during that cycle.
  - DONE→IDLE: unconditional on the next edge; done←0.
- stop=1 in RUN or DONE: next edge goes to IDLE with tick_out=0, busy=0, done=0. No done pulse is produced by an abort.
- stop and start both high in IDLE: stop wins; the block stays IDLE.
- start held high: it retriggers only after the block returns to IDLE, i.e. one cycle after the done pulse.
- Table changes, and changes to cfg_last or loop, during RUN do not affect the running pattern.
- Arithmetic: all counters are unsigned. div_cnt and k_cur are BIT_SZ wide; left is CNT_SZ wide. No value can wrap, because reload happens at 0.
- Reset asserted mid-RUN: immediate async clear to the reset values above. No done pulse.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, RUN=1, DONE=2);
  - default BIT_SZ=16 and CNT_SZ=8;
  - the step-entry struct {k, len}.
- One natural sub-module: divclk_core, a divider with a synchronous load input and async active-low reset. It takes load, k_in and en, and produces tick and the counter value.
- The sequencer owns the table, the FSM, step_idx and the left counter.

Test Plan:
- Reset, then entry0={k=2,len=3}, last=0, loop=0, start at edge S → ticks at S+3, S+6, S+9; done high at S+10 only; busy low from S+10.
- Entries {k=0,len=2},{k=4,len=1}, last=1, loop=0 → ticks at S+1, S+2, then S+7; done at S+8; step_idx reads 1 from S+2.
- Entry0={k=1,len=0}, last=0, loop=1 → tick every 2 cycles, indefinitely; no done; stop at edge T gives tick_out=0 and busy=0 from T onward, and no done.
- cfg_we while busy writes entry0 k=9 → running pattern unchanged; after done, next start uses k=9.
- start=stop=1 in IDLE → busy stays 0; rst_n low mid-RUN → all outputs 0 immediately and table reads back 0.
- k=16'hFFFF, len=1 → single tick at S+65536, then done at S+65537.

Source files
------------

// File: rtl/divclk_seq_pkg.sv
// Shared types and defaults for the divclk_seq tick-pattern sequencer.
package divclk_seq_pkg;

  localparam int BIT_SZ_DEF = 16;
  localparam int CNT_SZ_DEF = 8;

  // Sequencer state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One pattern step at default widths: divisor k (period k+1) and tick count.
  typedef struct packed {
    logic [BIT_SZ_DEF-1:0] k;
    logic [CNT_SZ_DEF-1:0] len;
  } step_t;

endpackage

// File: rtl/divclk_seq_core.sv
// Reloadable divider: counts down from k and emits a registered one-cycle
// tick on the edge where the count is zero, reloading from k_in there.
module divclk_core #(
  parameter int BIT_SZ = 16
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  input  logic [BIT_SZ-1:0] k_in,
  output logic              tick,
  output logic [BIT_SZ-1:0] cnt
);

  localparam logic [BIT_SZ-1:0] ONE = BIT_SZ'(1);

  // Count down while enabled; load wins over reload so a new step can start
  // on the same edge that carries the previous step's last tick.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= en && (cnt == '0);
      if (load) begin
        cnt <= k_in;
      end else if (en) begin
        cnt <= (cnt == '0) ? k_in : cnt - ONE;
      end
    end
  end

endmodule

// File: rtl/divclk_seq.sv
// Tick-pattern sequencer: plays a table of (divisor, tick-count) steps through
// a reloadable divider, optionally looping, with busy/done handshake.
//
// Control handshake: start is level-sampled and acts only in IDLE; stop acts in
// any state and always wins over start; done pulses for one cycle only on
// natural completion; busy is high exactly while in RUN.
module divclk_seq
  import divclk_seq_pkg::*;
#(
  parameter int BIT_SZ = BIT_SZ_DEF,
  parameter int CNT_SZ = CNT_SZ_DEF,
  parameter int STEPS  = 4,
  localparam int IW    = $clog2(STEPS)
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [IW-1:0]     cfg_addr,
  input  logic [BIT_SZ-1:0] cfg_k,
  input  logic [CNT_SZ-1:0] cfg_len,
  input  logic [IW-1:0]     cfg_last,
  input  logic              loop,
  input  logic              start,
  input  logic              stop,
  output logic              tick_out,
  output logic              busy,
  output logic              done,
  output logic [IW-1:0]     step_idx,
  output logic [BIT_SZ-1:0] k_cur
);

  typedef struct packed {
    logic [BIT_SZ-1:0] k;
    logic [CNT_SZ-1:0] len;
  } entry_t;

  localparam logic [CNT_SZ-1:0] LEN_ONE = CNT_SZ'(1);
  localparam logic [IW-1:0]     IDX_ONE = IW'(1);

  state_t            state;
  logic              fin;      // final tick issued, DONE follows next edge
  entry_t            tbl [STEPS];
  logic [IW-1:0]     last_q;
  logic              loop_q;
  logic [CNT_SZ-1:0] left;

  logic [BIT_SZ-1:0] cnt;
  logic              zero;
  logic              go;
  logic              step_end;
  logic              advance;
  logic              load;
  logic              en;
  logic [IW-1:0]     idx_nxt;
  entry_t            nxt;
  logic [BIT_SZ-1:0] k_sel;

  // A zero tick count still plays one tick.
  function automatic logic [CNT_SZ-1:0] eff_len(input logic [CNT_SZ-1:0] len);
    return (len == '0) ? LEN_ONE : len;
  endfunction

  // Step sequencing decisions for the current cycle.
  always_comb begin
    go       = (state == IDLE) && start && !stop;
    zero     = (cnt == '0);
    en       = (state == RUN) && !fin && !stop;
    step_end = en && zero && (left == LEN_ONE);
    idx_nxt  = (step_idx == last_q) ? '0 : step_idx + IDX_ONE;
    advance  = step_end && ((step_idx != last_q) || loop_q);
    nxt      = go ? tbl[0] : tbl[idx_nxt];
    load     = go || advance;
    k_sel    = load ? nxt.k : k_cur;
  end

  divclk_core #(.BIT_SZ(BIT_SZ)) u_core (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .load   (load),
    .en     (en),
    .k_in   (k_sel),
    .tick   (tick_out),
    .cnt    (cnt)
  );

  // Step table; writable only while idle so a running pattern is stable.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STEPS; i++) tbl[i] <= '0;
    end else if (cfg_we && (state == IDLE)) begin
      tbl[cfg_addr] <= '{k: cfg_k, len: cfg_len};
    end
  end

  // Control FSM with registered busy/done, step index, divisor and tick budget.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      fin      <= 1'b0;
      step_idx <= '0;
      k_cur    <= '0;
      left     <= '0;
      last_q   <= '0;
      loop_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (go) begin
            state    <= RUN;
            busy     <= 1'b1;
            fin      <= 1'b0;
            last_q   <= cfg_last;
            loop_q   <= loop;
            step_idx <= '0;
            k_cur    <= tbl[0].k;
            left     <= eff_len(tbl[0].len);
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            fin   <= 1'b0;
          end else if (fin) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            fin   <= 1'b0;
          end else if (zero) begin
            if (advance) begin
              step_idx <= idx_nxt;
              k_cur    <= nxt.k;
              left     <= eff_len(nxt.len);
            end else begin
              left <= left - LEN_ONE;
              if (step_end) fin <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          fin   <= 1'b0;
        end
      endcase
    end
  end

endmodule
